// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one single-ported fixed-latency memory
// Data port wins by default; fetch is forced through after STARVE_MAX consecutive losses.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_rd,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [STV_W-1:0]   starve, starve_n;
  logic               grant_i, grant_d, err_n;
  logic               i_elig, d_elig, d_conflict;

  assign if_stall = if_rd & ~if_done;
  assign d_stall  = (d_rd | d_wr) & ~d_done;

  // A port receiving its done pulse this cycle must not be re-granted on the stale request.
  assign d_conflict = d_rd & d_wr;
  assign i_elig     = if_rd & ~if_done;
  assign d_elig     = (d_rd | d_wr) & ~d_conflict & ~d_done;

  always_comb begin
    state_n  = state;
    starve_n = starve;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        err_n = d_conflict;
        if (d_elig && i_elig) begin
          if (starve == STV_W'(STARVE_MAX)) begin
            grant_i = 1'b1;
          end else begin
            grant_d  = 1'b1;
            starve_n = starve + 1'b1;
          end
        end else if (d_elig) begin
          grant_d = 1'b1;
        end else if (i_elig) begin
          grant_i = 1'b1;
        end
        if (grant_i) starve_n = '0;
        if (grant_d)      state_n = BUSY_D;
        else if (grant_i) state_n = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (cnt == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      starve    <= '0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state   <= state_n;
      starve  <= starve_n;
      err     <= err_n;
      mem_en  <= grant_i | grant_d;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wr    <= d_wr;
        cnt       <= CNT_W'(MEM_LAT);
      end else if (grant_i) begin
        mem_addr <= if_addr;
        mem_wr   <= 1'b0;
        cnt      <= CNT_W'(MEM_LAT);
      end
      // cnt reaches zero in the cycle mem_rdata is valid; done follows one cycle later.
      if (state != IDLE) begin
        if (cnt == '0) begin
          if (state == BUSY_I) begin
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
          end else begin
            if (!mem_wr) d_rdata <= mem_rdata;
            d_done <= 1'b1;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule
